fp16_addsub_seq: RTL and testbench

Sequential IEEE-754 half-precision adder/subtractor that feeds the LCD display stage. It accepts two fp16 operands and an operation bit on a start pulse. It produces the rounded result after a fixed 4-cycle latency. It holds operands, operation and result in registers that drive the display wrapper's A, B, R and operation inputs.

---
 rtl/fp16_addsub_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_fp16_addsub_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fp16_addsub_seq.sv
// rtl/fp16_addsub_seq.sv - sequential fp16 add/subtract, fixed 4-cycle latency, registered A/B/R
module fp16_addsub_seq #(
    parameter logic [15:0] QNAN = 16'h7E00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_in,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        operation,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [15:0] R
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d, b_q, b_d, r_q, r_d, spec_val_q, spec_val_d;
    logic               op_q, op_d, done_q, done_d;
    logic               special_q, special_d, sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [13:0]        mag_l_q, mag_l_d, mag_s_q, mag_s_d, mant_q, mant_d;
    logic [14:0]        sum_q, sum_d;

    // Alignment datapath, evaluated from the captured operands during ALIGN
    logic [4:0]  ea, eb, el, dexp;
    logic [9:0]  fa, fb;
    logic        sa, sb, sl, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge, stk;
    logic [10:0] ma, mb, ml, ms;
    logic [13:0] mx, sh;
    logic        al_special;
    logic [15:0] al_val;

    always_comb begin
        ea     = a_q[14:10];
        eb     = b_q[14:10];
        fa     = a_q[9:0];
        fb     = b_q[9:0];
        sa     = a_q[15];
        sb     = b_q[15] ^ op_q;
        a_nan  = (ea == 5'd31) && (fa != 10'd0);
        b_nan  = (eb == 5'd31) && (fb != 10'd0);
        a_inf  = (ea == 5'd31) && (fa == 10'd0);
        b_inf  = (eb == 5'd31) && (fb == 10'd0);
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        ma     = a_zero ? 11'd0 : {1'b1, fa};
        mb     = b_zero ? 11'd0 : {1'b1, fb};
        a_ge   = (a_zero ? 15'd0 : a_q[14:0]) >= (b_zero ? 15'd0 : b_q[14:0]);
        if (a_ge) begin
            ml = ma; ms = mb; el = ea; sl = sa; dexp = ea - eb;
        end else begin
            ml = mb; ms = ma; el = eb; sl = sb; dexp = eb - ea;
        end
        mx  = {ms, 3'b000};
        stk = 1'b0;
        if (dexp >= 5'd14) begin
            sh = {13'd0, |ms};
        end else begin
            sh = mx >> dexp;
            for (int i = 0; i < 14; i++) begin
                if (i < int'(dexp)) stk = stk | mx[i];
            end
            sh[0] = sh[0] | stk;
        end
        al_special = 1'b1;
        al_val     = 16'h0000;
        if (a_nan || b_nan)     al_val = QNAN;
        else if (a_inf && b_inf) al_val = (sa == sb) ? {sa, 15'h7C00} : QNAN;
        else if (a_inf)          al_val = {sa, 15'h7C00};
        else if (b_inf)          al_val = {sb, 15'h7C00};
        else if (a_zero && b_zero) al_val = (sa && sb) ? 16'h8000 : 16'h0000;
        else                     al_special = 1'b0;
    end

    logic [14:0] add_sum;
    always_comb begin
        add_sum = sub_q ? ({1'b0, mag_l_q} - {1'b0, mag_s_q})
                        : ({1'b0, mag_l_q} + {1'b0, mag_s_q});
    end

    // Leading-zero count is a single-cycle priority encoder; highest set bit wins
    logic [3:0]        lz;
    logic signed [6:0] lz_ext, norm_exp;
    logic [13:0]       norm_mant;
    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (sum_q[i]) lz = 4'(13 - i);
        end
        lz_ext = {3'b000, lz};
        if (sum_q[14]) begin
            norm_mant = {sum_q[14:2], sum_q[1] | sum_q[0]};
            norm_exp  = exp_q + 7'sd1;
        end else begin
            norm_mant = sum_q[13:0] << lz;
            norm_exp  = exp_q - lz_ext;
        end
    end

    logic              rup;
    logic [11:0]       rm;
    logic signed [6:0] re;
    logic [9:0]        rf;
    logic [15:0]       packed_r;
    always_comb begin
        rup = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        rm  = {1'b0, mant_q[13:3]} + {11'd0, rup};
        re  = exp_q;
        rf  = rm[9:0];
        if (rm[11]) begin
            re = exp_q + 7'sd1;
            rf = rm[10:1];
        end
        if (special_q)         packed_r = spec_val_q;
        else if (zero_q)       packed_r = 16'h0000;
        else if (re >= 7'sd31) packed_r = {sign_q, 15'h7C00};
        else if (re <= 7'sd0)  packed_r = {sign_q, 15'h0000};
        else                   packed_r = {sign_q, re[4:0], rf};
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        r_d        = r_q;
        done_d     = 1'b0;
        special_d  = special_q;
        spec_val_d = spec_val_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        zero_d     = zero_q;
        exp_d      = exp_q;
        mag_l_d    = mag_l_q;
        mag_s_d    = mag_s_q;
        sum_d      = sum_q;
        mant_d     = mant_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = op_in;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                special_d  = al_special;
                spec_val_d = al_val;
                sign_d     = sl;
                sub_d      = sa ^ sb;
                exp_d      = {2'b00, el};
                mag_l_d    = {ml, 3'b000};
                mag_s_d    = sh;
                state_d    = ADD;
            end
            ADD: begin
                sum_d   = add_sum;
                state_d = NORM;
            end
            NORM: begin
                mant_d  = norm_mant;
                exp_d   = norm_exp;
                zero_d  = (sum_q == 15'd0);
                state_d = ROUND;
            end
            ROUND: begin
                r_d     = packed_r;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            op_q       <= 1'b0;
            r_q        <= 16'h0000;
            done_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_val_q <= 16'h0000;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            zero_q     <= 1'b0;
            exp_q      <= 7'sd0;
            mag_l_q    <= 14'd0;
            mag_s_q    <= 14'd0;
            sum_q      <= 15'd0;
            mant_q     <= 14'd0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            r_q        <= r_d;
            done_q     <= done_d;
            special_q  <= special_d;
            spec_val_q <= spec_val_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            zero_q     <= zero_d;
            exp_q      <= exp_d;
            mag_l_q    <= mag_l_d;
            mag_s_q    <= mag_s_d;
            sum_q      <= sum_d;
            mant_q     <= mant_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign operation = op_q;
    assign A         = a_q;
    assign B         = b_q;
    assign R         = r_q;

endmodule

// File: tb/tb_fp16_addsub_seq.sv
// tb/tb_fp16_addsub_seq.sv - directed-vector bench for fp16_addsub_seq
module tb_fp16_addsub_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op_in = 1'b0;
    logic [15:0] a_in = 16'h0000;
    logic [15:0] b_in = 16'h0000;
    logic        busy, done, operation;
    logic [15:0] A, B, R;

    int passed = 0;
    int total  = 0;

    fp16_addsub_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_in(op_in),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .operation(operation), .A(A), .B(B), .R(R)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic [15:0] exp_r);
        @(negedge clk);
        a_in = a; b_in = b; op_in = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".A"}, A, a);
        check({tag, ".B"}, B, b);
        check({tag, ".op"}, {15'd0, operation}, {15'd0, op});
        check({tag, ".busy"}, {15'd0, busy}, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".early_done"}, {15'd0, done}, 16'd0);
        @(posedge clk); #1;
        check({tag, ".done"}, {15'd0, done}, 16'd1);
        check({tag, ".R"}, R, exp_r);
        check({tag, ".busy_after"}, {15'd0, busy}, 16'd0);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {15'd0, done}, 16'd0);
    endtask

    int acc, first_acc, second_acc;
    logic pre_busy, seen_done;

    initial begin
        #2;
        check("rst.busy", {15'd0, busy}, 16'd0);
        check("rst.done", {15'd0, done}, 16'd0);
        check("rst.R", R, 16'h0000);
        check("rst.A", A, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        run_op("add_basic", 16'h3C00, 16'h4000, 1'b0, 16'h4200);
        run_op("cancel",    16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        run_op("sub",       16'h4200, 16'h3C00, 1'b1, 16'h4000);
        run_op("tie_even",  16'h3C00, 16'h1000, 1'b0, 16'h3C00);
        run_op("tie_up",    16'h3C01, 16'h1000, 1'b0, 16'h3C02);
        run_op("overflow",  16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
        run_op("inf_m_inf", 16'h7C00, 16'h7C00, 1'b1, 16'h7E00);
        run_op("nan_in",    16'h7E01, 16'h3C00, 1'b0, 16'h7E00);
        run_op("subnorm",   16'h0001, 16'h3C00, 1'b0, 16'h3C00);
        run_op("negzeros",  16'h8000, 16'h8000, 1'b0, 16'h8000);
        run_op("inf_p_fin", 16'h7C00, 16'h3C00, 1'b0, 16'h7C00);
        run_op("fin_m_inf", 16'h3C00, 16'h7C00, 1'b1, 16'hFC00);

        // start held high for 10 cycles
        @(negedge clk);
        a_in = 16'h3C00; b_in = 16'h4000; op_in = 1'b0; start = 1'b1;
        acc = 0; first_acc = -1; second_acc = -1;
        for (int i = 0; i < 10; i++) begin
            pre_busy = busy;
            @(posedge clk); #1;
            if (!pre_busy && busy) begin
                if (acc == 0) first_acc = i; else second_acc = i;
                acc++;
            end
        end
        start = 1'b0;
        check("hold.accepts", 16'(acc), 16'd2);
        check("hold.spacing", 16'(second_acc - first_acc), 16'd5);
        check("hold.R", R, 16'h4200);
        repeat (2) @(posedge clk);

        // start pulse while busy is ignored
        @(negedge clk);
        a_in = 16'h4200; b_in = 16'h3C00; op_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        a_in = 16'h7BFF; b_in = 16'h7BFF; op_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign.A", A, 16'h4200);
        check("ign.B", B, 16'h3C00);
        check("ign.R_held", R, 16'h4200);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        check("ign.done", {15'd0, done}, 16'd1);
        check("ign.R", R, 16'h4000);
        @(posedge clk); #1;
        check("ign.no_accept", {15'd0, busy}, 16'd0);
        check("ign.A_after", A, 16'h4200);

        // reset asserted mid-operation
        @(negedge clk);
        a_in = 16'h3C00; b_in = 16'h4000; op_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rstmid.busy", {15'd0, busy}, 16'd0);
        check("rstmid.done", {15'd0, done}, 16'd0);
        check("rstmid.R", R, 16'h0000);
        check("rstmid.A", A, 16'h0000);
        @(negedge clk) reset_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("rstmid.no_done", {15'd0, seen_done}, 16'd0);
        check("rstmid.idle", {15'd0, busy}, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
